// File: rtl/eco_equiv_sweeper.sv
// Exhaustive equivalence sweep controller: walks every 10-bit {A,B} operand
// pair through two external 3-bit netlists, holds each pair SETTLE cycles,
// compares masked outputs and records mismatch statistics.
module eco_equiv_sweeper #(
  parameter int SETTLE = 2
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic       abort,
  input  logic       stop_on_fail,
  input  logic [2:0] mask,
  input  logic [2:0] y_gold_i,
  input  logic [2:0] y_rev_i,
  output logic [4:0] A_o,
  output logic [4:0] B_o,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [10:0] fail_cnt,
  output logic [9:0] first_fail_vec,
  output logic [2:0] first_fail_diff
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_CMP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  logic [1:0] state;
  logic [9:0] vec;
  logic [3:0] settle_cnt;
  logic [2:0] mask_q;
  logic       stop_q;
  logic [2:0] diff;

  assign A_o  = vec[9:5];
  assign B_o  = vec[4:0];
  assign busy = (state == S_WAIT) || (state == S_CMP);
  assign diff = (y_gold_i ^ y_rev_i) & mask_q;

  // Sweep FSM plus result registers; abort wins over any CMP-side update
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state           <= S_IDLE;
      vec             <= '0;
      settle_cnt      <= '0;
      mask_q          <= '0;
      stop_q          <= 1'b0;
      done            <= 1'b0;
      pass            <= 1'b0;
      fail_cnt        <= '0;
      first_fail_vec  <= '0;
      first_fail_diff <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state           <= S_WAIT;
            vec             <= '0;
            settle_cnt      <= '0;
            fail_cnt        <= '0;
            first_fail_vec  <= '0;
            first_fail_diff <= '0;
            pass            <= 1'b0;
            mask_q          <= mask;
            stop_q          <= stop_on_fail;
          end
        end
        S_WAIT: begin
          if (abort) begin
            state      <= S_IDLE;
            vec        <= '0;
            settle_cnt <= '0;
            pass       <= 1'b0;
          end else if (settle_cnt == SETTLE_LAST) begin
            settle_cnt <= '0;
            state      <= S_CMP;
          end else begin
            settle_cnt <= settle_cnt + 4'd1;
          end
        end
        S_CMP: begin
          if (abort) begin
            state <= S_IDLE;
            vec   <= '0;
            pass  <= 1'b0;
          end else begin
            if (diff != 3'b000) begin
              fail_cnt <= fail_cnt + 11'd1;
              if (fail_cnt == '0) begin
                first_fail_vec  <= vec;
                first_fail_diff <= diff;
              end
            end
            // vec is never incremented past the last pair, so it cannot wrap
            if ((vec == 10'd1023) || (stop_q && (diff != 3'b000))) begin
              state <= S_DONE;
            end else begin
              vec   <= vec + 10'd1;
              state <= S_WAIT;
            end
          end
        end
        default: begin
          // DONE: fail_cnt already includes the final compare
          done  <= 1'b1;
          pass  <= (fail_cnt == '0);
          state <= S_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eco_equiv_sweeper.sv
// Randomized bench for eco_equiv_sweeper: a behavioural model scans the
// injected-difference table to predict counts, first mismatch and latency.
module tb_eco_equiv_sweeper;

  localparam int S = 2;

  logic       clk = 1'b0;
  logic       rst;
  logic       start, abort, stop_on_fail;
  logic [2:0] mask, y_gold_i, y_rev_i;
  logic [4:0] A_o, B_o;
  logic       busy, done, pass;
  logic [10:0] fail_cnt;
  logic [9:0] first_fail_vec;
  logic [2:0] first_fail_diff;

  logic [2:0] inj [1024];
  int checks = 0;
  int errors = 0;

  eco_equiv_sweeper #(.SETTLE(S)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .stop_on_fail(stop_on_fail), .mask(mask),
    .y_gold_i(y_gold_i), .y_rev_i(y_rev_i),
    .A_o(A_o), .B_o(B_o), .busy(busy), .done(done), .pass(pass),
    .fail_cnt(fail_cnt), .first_fail_vec(first_fail_vec),
    .first_fail_diff(first_fail_diff)
  );

  always #5 clk = ~clk;

  // two netlists: gold is a small arithmetic function, rev adds injected flips
  always_comb begin
    y_gold_i = 3'(A_o + B_o);
    y_rev_i  = y_gold_i ^ inj[{A_o, B_o}];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // model outputs
  int m_fc, m_ffv, m_ffd, m_cycles;

  task automatic model(input logic [2:0] m, input logic sof, input int upto);
    int last;
    m_fc = 0; m_ffv = 0; m_ffd = 0; last = upto - 1;
    for (int v = 0; v < upto; v++) begin
      logic [2:0] d;
      d = inj[v] & m;
      if (d != 0) begin
        if (m_fc == 0) begin m_ffv = v; m_ffd = d; end
        m_fc++;
        if (sof) begin last = v; break; end
      end
    end
    m_cycles = (last + 1) * (S + 1) + 1;
  endtask

  task automatic pulse_start(input logic [2:0] m, input logic sof);
    @(negedge clk);
    mask = m; stop_on_fail = sof; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
  endtask

  // full sweep: checks operand sequencing every cycle, then final results
  task automatic run_sweep(input string tag, input logic [2:0] m, input logic sof);
    int c, n, bad;
    model(m, sof, 1024);
    n = m_cycles - 1;
    bad = 0;
    pulse_start(m, sof);
    c = 0;
    while (c <= 4000) begin
      @(negedge clk);
      if (c < n) begin
        if ({A_o, B_o} !== 10'(c / (S + 1)) || busy !== 1'b1 || done !== 1'b0 || pass !== 1'b0) bad++;
      end else if (c == n) begin
        if (busy !== 1'b0 || done !== 1'b0) bad++;
      end
      if (done) break;
      c++;
    end
    chk({tag, "_seq"}, bad, 0);
    chk({tag, "_cycles"}, c, m_cycles);
    chk({tag, "_pass"}, pass, (m_fc == 0));
    chk({tag, "_fcnt"}, fail_cnt, m_fc);
    chk({tag, "_ffv"}, first_fail_vec, m_ffv);
    chk({tag, "_ffd"}, first_fail_diff, m_ffd);
    @(negedge clk);
    chk({tag, "_pulse"}, done, 0);
  endtask

  task automatic wait_vec(input int target, output int cyc);
    cyc = 0;
    while ({A_o, B_o} != 10'(target) && cyc < 4000) begin
      @(negedge clk);
      cyc++;
    end
    if (cyc >= 4000) chk("wait_vec_timeout", cyc, 0);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_ab"}, {A_o, B_o}, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_done"}, done, 0);
    chk({tag, "_pass"}, pass, 0);
    chk({tag, "_fcnt"}, fail_cnt, 0);
    chk({tag, "_ff"}, {first_fail_vec, first_fail_diff}, 0);
  endtask

  task automatic clear_inj();
    for (int v = 0; v < 1024; v++) inj[v] = 3'b000;
  endtask

  initial begin
    int cyc;
    rst = 1'b1; start = 1'b0; abort = 1'b0; stop_on_fail = 1'b0; mask = 3'b111;
    clear_inj();
    repeat (2) @(negedge clk);
    chk_zero("reset");
    rst = 1'b0;

    // identical netlists
    run_sweep("equal", 3'b111, 1'b0);

    // single bit2 flip at A=3,B=0
    inj[10'h060] = 3'b100;
    run_sweep("bit2", 3'b111, 1'b0);
    run_sweep("masked", 3'b011, 1'b0);
    run_sweep("mask0", 3'b000, 1'b0);

    // stop at first of two mismatches
    clear_inj();
    inj[5] = 3'b010; inj[9] = 3'b001;
    run_sweep("stop", 3'b111, 1'b1);

    // random injection tables, masks and stop modes
    for (int r = 0; r < 4; r++) begin
      for (int v = 0; v < 1024; v++)
        inj[v] = ($urandom_range(0, 47) == 0) ? 3'($urandom) : 3'b000;
      run_sweep($sformatf("rnd%0d", r), 3'($urandom), 1'($urandom));
    end

    // reset mid-sweep at vec 300
    clear_inj();
    pulse_start(3'b111, 1'b0);
    wait_vec(300, cyc);
    rst = 1'b1;
    #1;
    chk_zero("midrst");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    run_sweep("after_rst", 3'b111, 1'b0);

    // stray start at vec 50 ignored, abort at vec 100
    for (int v = 0; v < 1024; v++)
      inj[v] = ($urandom_range(0, 15) == 0) ? 3'b111 : 3'b000;
    model(3'b111, 1'b0, 100);
    pulse_start(3'b111, 1'b0);
    wait_vec(50, cyc);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("no_restart", {A_o, B_o}, 50);
    wait_vec(100, cyc);
    abort = 1'b1;
    @(posedge clk); #1;
    abort = 1'b0;
    @(negedge clk);
    chk("abort_busy", busy, 0);
    chk("abort_ab", {A_o, B_o}, 0);
    chk("abort_pass", pass, 0);
    chk("abort_fcnt", fail_cnt, m_fc);
    chk("abort_ffv", first_fail_vec, m_ffv);
    cyc = 0;
    repeat (6) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) cyc++;
    end
    chk("abort_nodone", cyc, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/eco_equiv_sweeper.md
ECO_EQUIV_SWEEPER -- requirements
Module: eco_equiv_sweeper

Purpose: exhaustive sweep controller that feeds every 5-bit A/B operand pair to two external combinational netlists (original and ECO-patched, 3-bit outputs) and compares their outputs.

Interface
REQ-001 The module SHALL have parameter SETTLE, default 2, meaning the number of cycles the operands are held before outputs are sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on the rising edge.
REQ-003 rst  input  1  reset, asynchronous and active-high.
REQ-004 start  input  1  begin sweep; sampled only in IDLE.
REQ-005 abort  input  1  terminate sweep; return to IDLE without a done pulse.
REQ-006 stop_on_fail  input  1  end the sweep at the first mismatch; sampled with start.
REQ-007 mask  input  3  compare-enable per output bit; sampled with start.
REQ-008 y_gold_i  input  3  output of the original netlist.
REQ-009 y_rev_i  input  3  output of the patched netlist.
REQ-010 A_o  output  5  operand A driven to both netlists.
REQ-011 B_o  output  5  operand B driven to both netlists.
REQ-012 busy  output  1  high in WAIT and CMP.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 pass  output  1  result of the last completed sweep.
REQ-015 fail_cnt  output  11  number of mismatching vectors, 0..1024.
REQ-016 first_fail_vec  output  10  {A,B} of the first mismatch.
REQ-017 first_fail_diff  output  3  masked XOR of the outputs at the first mismatch.

Function
REQ-018 The FSM SHALL have states IDLE, WAIT, CMP, DONE.
REQ-019 The vector counter vec[9:0] SHALL drive A_o=vec[9:5] and B_o=vec[4:0].
REQ-020 IDLE with start=1 SHALL go to WAIT and clear vec, the settle counter, fail_cnt, first_fail_vec, first_fail_diff and pass, and latch mask and stop_on_fail.
REQ-021 WAIT SHALL count SETTLE cycles with A_o/B_o stable, then go to CMP.
REQ-022 CMP SHALL compute diff=(y_gold_i ^ y_rev_i) & mask_latched.
REQ-023 If diff!=0, CMP SHALL increment fail_cnt and, only when this is the first mismatch, capture vec and diff.
REQ-024 CMP SHALL go to DONE if vec==1023, or if stop_on_fail_latched=1 and diff!=0.
REQ-025 Otherwise CMP SHALL increment vec and go to WAIT.
REQ-026 Each vector SHALL take exactly SETTLE+1 cycles.
REQ-027 A full sweep SHALL assert done 1024*(SETTLE+1)+1 cycles after the start-sampling edge.
REQ-028 DONE SHALL assert done for one cycle, set pass=(fail_cnt==0 after the final compare), and return to IDLE.
REQ-029 Results (pass, fail_cnt, first_fail_*) SHALL hold until the next accepted start.
REQ-030 start while busy SHALL be ignored.
REQ-031 abort in WAIT or CMP SHALL go to IDLE next cycle: vec=0, pass=0, no done pulse, counts frozen as they stand.
REQ-032 abort SHALL take priority over a same-cycle CMP transition.
REQ-033 abort in IDLE or DONE SHALL have no effect.
REQ-034 vec SHALL never wrap; fail_cnt SHALL never exceed 1024.
REQ-035 When mask=3'b000, every vector SHALL compare equal.

Reset
REQ-036 rst=1 SHALL immediately force IDLE, vec=0, A_o=0, B_o=0, busy=0, done=0, pass=0, fail_cnt=0, first_fail_vec=0, first_fail_diff=0, latched mask=0, latched stop_on_fail=0.
REQ-037 Reset mid-sweep SHALL discard all progress; a start after release SHALL begin again at vec=0.

Verification
REQ-038 SETTLE=2, y_rev_i=y_gold_i, mask=3'b111, start -> done 3073 cycles later; pass=1; fail_cnt=0.
REQ-039 y_rev_i differs only in bit2 at A=3, B=0, mask=3'b111 -> fail_cnt=1; first_fail_vec=10'h060; first_fail_diff=3'b100; pass=0.
REQ-040 Same stimulus as REQ-039 with mask=3'b011 -> pass=1; fail_cnt=0.
REQ-041 y_rev_i differs at vec 5 and vec 9, stop_on_fail=1 -> done after vec 5 compare (6*(SETTLE+1)+1 cycles); fail_cnt=1; first_fail_vec=5.
REQ-042 Assert rst at vec=300, then start after release -> all outputs 0 during reset; A_o/B_o restart at 0; full 3073-cycle sweep follows.
REQ-043 abort at vec=100 -> IDLE next cycle with no done pulse; a start during the sweep is ignored with no restart.
